// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
//   state_e   : sequencer states (S_IDLE, S_ISSUE, S_CAPT, S_RESP)
//   SIZE_*    : access-size encodings on req_size / mem_size
//   NUM_REQ   : number of requesters
//   idx2oh    : requester index to one-hot vector
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_CAPT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;
  localparam int   NUM_REQ   = 2;

  function automatic logic [NUM_REQ-1:0] idx2oh(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way grant.
//   req_valid  [1:0] in  : request bits
//   rr_last          in  : index granted most recently
//   fixed_prio       in  : 1 = requester 0 always wins a tie
//   grant      [1:0] out : one-hot grant (0 when nothing requests)
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               rr_last,
  input  logic               fixed_prio,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    grant = '0;
    unique case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // On a tie the requester that did not go last wins.
      2'b11:   grant = (fixed_prio || rr_last) ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter/sequencer for the 1 KB single-port
// data memory. One access in flight; strobes last one cycle; registered
// read data is captured and returned with an error flag.
//   clk, reset (sync, active-high)
//   req_*   : per-requester request channel (valid/ready)
//   resp_*  : per-requester response channel (one-hot valid, shared data/err)
//   mem_*   : memory strobes, address, write data and registered read data
// Build option: DMEM_ARB_FIXED_PRIO_EN gives requester 0 fixed tie priority.
//
// state   | meaning
// S_IDLE  | arbitrate, accept one request
// S_ISSUE | drive memory strobe for one cycle
// S_CAPT  | wait for registered read data, capture it
// S_RESP  | hold response until the owning requester accepts
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_we,
  input  logic [1:0]            req_size,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [63:0]           req_wdata,
  output logic [1:0]            resp_valid,
  input  logic [1:0]            resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_size,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
  localparam logic FIXED_PRIO = 1'b1;
`else
  localparam logic FIXED_PRIO = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LIM_BYTE = ADDR_W'(MEM_BYTES);
  localparam logic [ADDR_W-1:0] LIM_WORD = ADDR_W'(MEM_BYTES - 4);

  state_e              state_q, state_d;
  logic                idx_q, we_q, size_q, rr_last_q, err_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q, rdata_q;

  logic [1:0]          grant;
  logic                hs, sel, sel_we, sel_size, acc_err;
  logic [ADDR_W-1:0]   sel_addr;
  logic [31:0]         sel_wdata;

  rr_arb2 u_arb (
    .req_valid  (req_valid),
    .rr_last    (rr_last_q),
    .fixed_prio (FIXED_PRIO),
    .grant      (grant)
  );

  // Grant is one-hot, so bit 1 is the winning index.
  assign sel       = grant[1];
  assign sel_we    = req_we[sel];
  assign sel_size  = req_size[sel];
  assign sel_addr  = sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
  assign sel_wdata = sel ? req_wdata[63:32] : req_wdata[31:0];

  always_comb begin
    if (sel_size == SIZE_WORD)
      acc_err = (sel_addr[1:0] != 2'b00) || (sel_addr > LIM_WORD);
    else
      acc_err = (sel_addr >= LIM_BYTE);
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = '0;
    resp_valid = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_size   = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    hs         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = reset ? 2'b00 : grant;
        hs        = |(req_valid & req_ready);
        if (hs) state_d = acc_err ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        mem_read  = ~we_q;
        mem_write = we_q;
        mem_size  = size_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        state_d   = we_q ? S_RESP : S_CAPT;
      end
      S_CAPT: state_d = S_RESP;
      S_RESP: begin
        resp_valid = idx2oh(idx_q);
        if (resp_ready[idx_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= 1'b0;
      we_q      <= 1'b0;
      size_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rr_last_q <= 1'b1;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        idx_q     <= sel;
        we_q      <= sel_we;
        size_q    <= sel_size;
        addr_q    <= sel_addr;
        wdata_q   <= sel_wdata;
        rr_last_q <= sel;
        err_q     <= acc_err;
      end
      if (state_q == S_CAPT) rdata_q <= mem_rdata;
      if (state_q == S_RESP && resp_ready[idx_q]) err_q <= 1'b0;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready, req_we, req_size;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err, mem_size, mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int vec_cnt = 0;
  int err_cnt = 0;
  int rd_cnt  = 0;
  int wr_cnt  = 0;

  logic [7:0] mem [1024];

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_size(mem_size), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory model: synchronous write, registered read data.
  always @(posedge clk) begin
    if (mem_write) begin
      wr_cnt++;
      mem[mem_addr[9:0]] <= mem_wdata[7:0];
      if (mem_size) begin
        mem[mem_addr[9:0] + 10'd1] <= mem_wdata[15:8];
        mem[mem_addr[9:0] + 10'd2] <= mem_wdata[23:16];
        mem[mem_addr[9:0] + 10'd3] <= mem_wdata[31:24];
      end
    end
    if (mem_read) begin
      rd_cnt++;
      if (mem_size)
        mem_rdata <= {mem[mem_addr[9:0] + 10'd3], mem[mem_addr[9:0] + 10'd2],
                      mem[mem_addr[9:0] + 10'd1], mem[mem_addr[9:0]]};
      else
        mem_rdata <= {24'h0, mem[mem_addr[9:0]]};
    end
  end

  function automatic logic [31:0] mword(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One complete transaction from requester idx, starting and ending at a negedge.
  task automatic xfer(input int idx, input logic we, input logic sz,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic exp_err, input logic chk_rd,
                      input logic [31:0] exp_rd);
    int lat, rd0, wr0, exp_lat;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    req_valid[idx]           = 1'b1;
    req_we[idx]              = we;
    req_size[idx]            = sz;
    req_addr[idx*32 +: 32]   = addr;
    req_wdata[idx*32 +: 32]  = wd;
    #1 check("req_ready", {30'h0, req_ready}, 32'(1 << idx));
    @(posedge clk);
    @(negedge clk);
    req_valid[idx] = 1'b0;
    lat = 1;
    while (resp_valid[idx] !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    exp_lat = exp_err ? 1 : (we ? 2 : 3);
    check("latency", 32'(lat), 32'(exp_lat));
    check("resp_err", {31'h0, resp_err}, {31'h0, exp_err});
    if (chk_rd) check("resp_rdata", resp_rdata, exp_rd);
    check("rd_strobes", 32'(rd_cnt - rd0), (!exp_err && !we) ? 32'd1 : 32'd0);
    check("wr_strobes", 32'(wr_cnt - wr0), (!exp_err && we) ? 32'd1 : 32'd0);
    resp_ready[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready[idx] = 1'b0;
  endtask

  initial begin
    int gcnt;
    int gnt [4];
    logic [31:0] held;
    logic any_resp;

    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem_rdata  = '0;
    reset      = 1'b1;
    req_valid  = '0;
    req_we     = '0;
    req_size   = '0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = '0;

    repeat (3) @(negedge clk);
    req_valid = 2'b11;
    #1;
    check("rst_req_ready", {30'h0, req_ready}, 32'h0);
    check("rst_outs", {resp_valid, resp_err, mem_read, mem_write, mem_size, 26'h0}, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    req_valid = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Word write then read back.
    xfer(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    xfer(0, 1'b0, 1'b1, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
    // Byte write then byte read.
    xfer(1, 1'b1, 1'b0, 32'h55, 32'h000000A7, 1'b0, 1'b0, 32'h0);
    xfer(0, 1'b0, 1'b0, 32'h55, 32'h0, 1'b0, 1'b1, 32'h000000A7);

    // Range and alignment boundaries.
    xfer(0, 1'b0, 1'b1, 32'h3FC, 32'h0, 1'b0, 1'b1, mword(32'h3FC));
    xfer(0, 1'b0, 1'b1, 32'h3FD, 32'h0, 1'b1, 1'b1, mword(32'h3FC));
    xfer(0, 1'b0, 1'b0, 32'h400, 32'h0, 1'b1, 1'b0, 32'h0);
    xfer(0, 1'b0, 1'b0, 32'h3FF, 32'h0, 1'b0, 1'b1, {24'h0, mem[1023]});
    xfer(0, 1'b0, 1'b1, 32'h400, 32'h0, 1'b1, 1'b0, 32'h0);
    // Requester 1 misaligned read; also leaves rr_last = 1.
    xfer(1, 1'b0, 1'b1, 32'h102, 32'h0, 1'b1, 1'b0, 32'h0);

    // Both requesters contending.
    req_we     = 2'b00;
    req_size   = 2'b11;
    req_addr   = {32'h40, 32'h20};
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    gcnt = 0;
    for (int c = 0; c < 30 && gcnt < 4; c++) begin
      #1;
      if ((req_valid & req_ready) != 2'b00) begin
        gnt[gcnt] = req_ready[1] ? 1 : 0;
        gcnt++;
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    repeat (6) @(negedge clk);
    resp_ready = 2'b00;
    check("grant_count", 32'(gcnt), 32'd4);
    for (int g = 0; g < 4; g++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      check($sformatf("grant%0d", g), 32'(gnt[g]), 32'd0);
`else
      check($sformatf("grant%0d", g), 32'(gnt[g]), 32'(g % 2));
`endif
    end
    check("rr_rdata", resp_rdata, mword(32'h40 - 32'h20 * 32'(gnt[3] == 0)));

    // Response stall with a pending requester 1.
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_size[0] = 1'b1;
    req_addr[31:0] = 32'h10;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_size[1] = 1'b1;
    req_addr[63:32] = 32'h40;
    repeat (2) @(negedge clk);
    held = resp_rdata;
    check("stall_rdata", held, 32'hDEADBEEF);
    for (int s = 0; s < 5; s++) begin
      check("stall_valid", {30'h0, resp_valid}, 32'h1);
      check("stall_ready", {30'h0, req_ready}, 32'h0);
      check("stall_hold", resp_rdata, held);
      resp_ready[1] = 1'b1;
      @(negedge clk);
    end
    resp_ready = 2'b01;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 2'b00;
    #1 check("pending_grant", {30'h0, req_ready}, 32'h2);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    check("pending_rdata", resp_rdata, mword(32'h40));
    check("pending_valid", {30'h0, resp_valid}, 32'h2);
    resp_ready = 2'b10;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 2'b00;

    // Reset during CAPT drops the transaction.
    req_valid[0] = 1'b1; req_addr[31:0] = 32'h3FC;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("capt_strobe", {30'h0, mem_read, mem_write}, 32'h0);
    @(negedge clk);
    check("rst_capt_outs",
          {req_ready, resp_valid, resp_err, mem_read, mem_write, mem_size, 24'h0}, 32'h0);
    check("rst_capt_addr", mem_addr | mem_wdata, 32'h0);
    check("rst_capt_rdata", resp_rdata, 32'h0);
    reset = 1'b0;
    any_resp = 1'b0;
    for (int w = 0; w < 6; w++) begin
      @(negedge clk);
      if (resp_valid != 2'b00) any_resp = 1'b1;
    end
    check("no_resp_after_rst", {31'h0, any_resp}, 32'h0);
    // First tie after reset goes to requester 0.
    req_addr  = {32'h40, 32'h20};
    req_valid = 2'b11;
    #1 check("tie_after_rst", {30'h0, req_ready}, 32'h1);
    req_valid = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
